hamming_secded_stream_encode: RTL and testbench
===============================================

// Module: hamming_secded_stream_encode
// PURPOSE
//  Pipelined, valid/ready streaming SECDED encoder. Splits a DATA_WIDTH word into NUM_SEGMENTS
//  equal segments and Hamming(SEC)+overall-parity encodes each one. Concatenates (or interleaves)
//  the segment codewords into one output word. Sits between a producer and a storage/link stage.
//  Successor to the single-word combinational encoder: adds segmentation, registered pipeline,
//  backpressure and a sequence tag.
// PARAMETERS
//  DATA_WIDTH   32  input data bits; must be divisible by NUM_SEGMENTS (elaboration $error otherwise)
//  NUM_SEGMENTS 4   independent SECDED codewords per input word (>=1)
//  SEQ_WIDTH    8   width of wrapping output sequence tag
//  Derived: SEG_WIDTH=DATA_WIDTH/NUM_SEGMENTS; ADDR_WIDTH=hamming_address_width(SEG_WIDTH);
//           SEG_CODE_WIDTH=SEG_WIDTH+ADDR_WIDTH+1; OUTPUT_WIDTH=NUM_SEGMENTS*SEG_CODE_WIDTH
// PORTS
//  clk        in   1             clock, all logic rising-edge
//  rst        in   1             reset: one clock; synchronous, active-high
//  in_valid   in   1             input word valid
//  in_ready   out  1             block can accept input this cycle
//  data_in    in   DATA_WIDTH    data word
//  out_valid  out  1             encoded word valid
//  out_ready  in   1             consumer accepts output this cycle
//  data_out   out  OUTPUT_WIDTH  encoded word
//  out_seq    out  SEQ_WIDTH     index of this output word, modulo 2**SEQ_WIDTH
// BEHAVIOUR
//  Reset (rst=1 at clk edge): both stage valids=0, out_valid=0, out_seq counter=0, data_out=0;
//   in_ready=1 from the first cycle after reset. Reset mid-stream drops all in-flight words.
//  Pipeline: S1 registers data_in; S2 registers encoded result + seq. Latency 2 clk from
//   accept (in_valid&&in_ready) to out_valid. Throughput 1 word/clk when out_ready=1.
//  Handshake: transfer on valid&&ready. Stage advances if its successor is empty or draining:
//   s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//   in_ready is combinational from out_ready. No bubble insertion, no word dropped or duplicated.
//  While out_valid && !out_ready: data_out and out_seq stay stable.
//  in_valid may drop without handshake; data_in is sampled only on accept.
//  Simultaneous S2 drain + S1 move + new accept in one cycle: all three occur.
//  out_seq increments by 1 on each output transfer (out_valid&&out_ready). It wraps
//   2**SEQ_WIDTH-1 -> 0. The value shown is the tag of the word currently presented.
//  Segment s = data_in[s*SEG_WIDTH +: SEG_WIDTH].
//  Codeword layout per segment (unchanged from existing decoder convention):
//   bit 0 = XOR of bits [SEG_CODE_WIDTH-1:1]; bits 2**i = parity i, i<ADDR_WIDTH;
//   data bits LSB-first into remaining positions ascending from bit 3.
//   parity = XOR of the indices of all set data positions.
//  Output layout (default): segment s at data_out[s*SEG_CODE_WIDTH +: SEG_CODE_WIDTH].
// CONFIGURATION
//  Macro HAMMING_INTERLEAVE_EN:
//   defined -> bit j of segment s goes to data_out[j*NUM_SEGMENTS+s]. A burst of up to
//     NUM_SEGMENTS adjacent bit errors then hits each codeword at most once.
//   undefined -> concatenated layout above. No other behaviour or timing difference.
// STRUCTURE
//  gray_area_package: reuse hamming_address_width(). Add hamming_code_width(data_w) and
//   hamming_is_parity_pos(idx). These are shared with the decoder.
//  Sub-module hamming_secded_segment_encode #(SEG_WIDTH): combinational pack + parity +
//   overall parity for one segment. Instantiate NUM_SEGMENTS times in a generate loop.
// TESTING (DATA_WIDTH=32, NUM_SEGMENTS=4 -> SEG_CODE_WIDTH=13, OUTPUT_WIDTH=52)
//  rst=1 for 2 clk, then idle -> out_valid=0, data_out=0, in_ready=1, out_seq=0.
//  data_in=32'h0, out_ready=1 -> 2 clk later data_out=52'h0, out_seq=0.
//  data_in=32'hFFFFFFFF -> each 13-bit segment =13'h1EEE.
//   data_in=32'h00000001 -> seg0=13'h000F, seg1..3=0.
//  Back-to-back 6 words with out_ready toggling 1,0,0,1,... -> all 6 out in order, no loss;
//   data_out stable while stalled; out_seq 0..5.
//  SEQ_WIDTH=2, send 5 words -> out_seq 0,1,2,3,0.
//   Assert rst with 2 words in flight -> next cycle out_valid=0, out_seq=0.
//  HAMMING_INTERLEAVE_EN, data_in=32'h00000001 -> data_out bits 0,4,8,12 set, all others 0.
//   Scoreboard: decode via reference model, inject every single-bit error -> corrected.

Source files
------------

// File: rtl/hamming_secded_stream_encode_pkg.sv
// Shared Hamming helpers for the SECDED encoder and its matching decoder.
// Latency: none (elaboration-time constant functions only).
// Backpressure: not applicable.
//
// Functions:
//   hamming_address_width(data_w) - number of Hamming parity bits needed for data_w data bits
//   hamming_code_width(data_w)    - data + parity + overall-parity bit count
//   hamming_is_parity_pos(idx)    - 1 when codeword position idx holds a Hamming parity bit
package hamming_secded_stream_encode_pkg;

    // Smallest r with 2**r >= data_w + r + 1.
    function automatic int hamming_address_width(input int data_w);
        for (int r = 1; r < 31; r++) begin
            if ((1 << r) >= (data_w + r + 1)) begin
                return r;
            end
        end
        return 31;
    endfunction

    // Position 0 carries the overall parity, so the codeword is one bit
    // wider than the plain Hamming code.
    function automatic int hamming_code_width(input int data_w);
        return data_w + hamming_address_width(data_w) + 1;
    endfunction

    // Parity bits sit at the non-zero powers of two.
    function automatic bit hamming_is_parity_pos(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

endpackage

// File: rtl/hamming_secded_segment_encode.sv
// SECDED encode of one segment: place data, compute Hamming parity and overall parity.
// Latency: purely combinational, 0 clk.
// Backpressure: none; output follows input.
//
// Ports:
//   i_data  in  SEG_WIDTH   segment data bits
//   o_code  out CODE_WIDTH  codeword; bit 0 overall parity, bits 2**i parity i,
//                           data LSB-first in the remaining positions from bit 3 upward
module hamming_secded_segment_encode
    import hamming_secded_stream_encode_pkg::*;
#(
    parameter  int SEG_WIDTH  = 8,
    localparam int ADDR_WIDTH = hamming_address_width(SEG_WIDTH),
    localparam int CODE_WIDTH = hamming_code_width(SEG_WIDTH)
) (
    input  logic [SEG_WIDTH-1:0]  i_data,
    output logic [CODE_WIDTH-1:0] o_code
);

    // Hamming body: everything above the overall parity bit.
    logic [CODE_WIDTH-1:1] w_body;
    // XOR of the positions of all set data bits; bit i of it is parity i.
    logic [ADDR_WIDTH-1:0] w_syn;

    always_comb begin
        int k;
        w_body = '0;
        w_syn  = '0;
        k      = 0;
        for (int p = 1; p < CODE_WIDTH; p++) begin
            if (!hamming_is_parity_pos(p)) begin
                w_body[p] = i_data[k];
                if (i_data[k]) begin
                    w_syn = w_syn ^ p[ADDR_WIDTH-1:0];
                end
                k = k + 1;
            end
        end
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            w_body[1 << i] = w_syn[i];
        end
    end

    // Overall parity makes the whole codeword even, giving double-error detection.
    assign o_code = {w_body, ^w_body};

endmodule

// File: rtl/hamming_secded_stream_encode.sv
// Two-stage valid/ready SECDED encoder: segments a data word, encodes each segment, tags outputs.
// Latency: 2 clk from accept (in_valid && in_ready) to out_valid; 1 word/clk when out_ready=1.
// Backpressure: in_ready is combinational from out_ready; stalled output holds data_out/out_seq.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake, data_in sampled on accept
//   data_in             DATA_WIDTH data word
//   out_valid/out_ready output handshake
//   data_out            NUM_SEGMENTS concatenated (or interleaved) segment codewords
//   out_seq             tag of the presented word, +1 per output transfer, wrapping
// Configuration macro HAMMING_INTERLEAVE_EN: when defined, bit j of segment s is placed at
//   data_out[j*NUM_SEGMENTS+s] so an adjacent-bit burst of up to NUM_SEGMENTS bits touches each
//   codeword at most once; otherwise segment s occupies data_out[s*SEG_CODE_WIDTH +: SEG_CODE_WIDTH].
module hamming_secded_stream_encode
    import hamming_secded_stream_encode_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int NUM_SEGMENTS   = 4,
    parameter  int SEQ_WIDTH      = 8,
    localparam int SEG_WIDTH      = DATA_WIDTH / NUM_SEGMENTS,
    localparam int SEG_CODE_WIDTH = hamming_code_width(SEG_WIDTH),
    localparam int OUTPUT_WIDTH   = NUM_SEGMENTS * SEG_CODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic [SEQ_WIDTH-1:0]    out_seq
);

    if ((NUM_SEGMENTS < 1) || ((DATA_WIDTH % NUM_SEGMENTS) != 0)) begin : g_bad_cfg
        $error("DATA_WIDTH must be divisible by NUM_SEGMENTS (NUM_SEGMENTS >= 1)");
    end

    logic                      r_s1_valid;
    logic [DATA_WIDTH-1:0]     r_s1_data;
    logic                      r_s2_valid;
    logic [OUTPUT_WIDTH-1:0]   r_s2_data;
    logic [SEQ_WIDTH-1:0]      r_seq;

    logic                      w_s1_adv;
    logic                      w_s2_adv;
    logic [OUTPUT_WIDTH-1:0]   w_encoded;
    logic [SEG_CODE_WIDTH-1:0] w_seg_code [NUM_SEGMENTS];

    // A stage may load when it is empty or its content leaves this cycle,
    // so a full pipeline with out_ready=1 moves every stage at once.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    for (genvar s = 0; s < NUM_SEGMENTS; s++) begin : g_seg
        hamming_secded_segment_encode #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg_enc (
            .i_data (r_s1_data[s*SEG_WIDTH +: SEG_WIDTH]),
            .o_code (w_seg_code[s])
        );

`ifdef HAMMING_INTERLEAVE_EN
        for (genvar j = 0; j < SEG_CODE_WIDTH; j++) begin : g_bit
            assign w_encoded[j*NUM_SEGMENTS + s] = w_seg_code[s][j];
        end
`else
        assign w_encoded[s*SEG_CODE_WIDTH +: SEG_CODE_WIDTH] = w_seg_code[s];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_seq      <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= data_in;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_encoded;
                end
            end
            // The tag belongs to the presented word and moves on only when it is taken.
            if (r_s2_valid && out_ready) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign data_out  = r_s2_data;
    assign out_seq   = r_seq;

endmodule

// File: tb/tb_hamming_secded_stream_encode.sv
// Bench for hamming_secded_stream_encode (DATA_WIDTH=32, NUM_SEGMENTS=4, SEQ_WIDTH=2).
// A queue-based reference model predicts every transferred output word and tag; directed
// vectors pin hand-computed codewords, stalls, sequence wrap and mid-stream reset.
module tb_hamming_secded_stream_encode;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int SQ = 2;
    localparam int SW = 8;
    localparam int CW = 13;
    localparam int OW = 52;

`ifdef HAMMING_INTERLEAVE_EN
    localparam logic [OW-1:0] LIT_ONES = 52'hFFFF0FFF0FFF0;
    localparam logic [OW-1:0] LIT_ONE  = 52'h0000000001111;
`else
    localparam logic [OW-1:0] LIT_ONES = {4{13'h1EEE}};
    localparam logic [OW-1:0] LIT_ONE  = 52'h000000000000F;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_in   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] data_out;
    logic [SQ-1:0] out_seq;

    always #5 clk = ~clk;

    hamming_secded_stream_encode #(
        .DATA_WIDTH   (DW),
        .NUM_SEGMENTS (NS),
        .SEQ_WIDTH    (SQ)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_seq   (out_seq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Textbook Hamming: data fills non-power-of-two positions, parity i makes the
    // XOR of every position with address bit i set equal to zero; bit 0 evens the word.
    function automatic logic [CW-1:0] ref_seg(input logic [SW-1:0] d);
        logic [CW-1:0] c;
        int k;
        logic p;
        c = '0;
        k = 0;
        for (int q = 1; q < CW; q++) begin
            if ((q & (q - 1)) != 0) begin
                c[q] = d[k];
                k++;
            end
        end
        for (int i = 0; (1 << i) < CW; i++) begin
            p = 1'b0;
            for (int q = 1; q < CW; q++) begin
                if (q[i]) p = p ^ c[q];
            end
            c[1 << i] = p;
        end
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [OW-1:0] ref_word(input logic [DW-1:0] d);
        logic [OW-1:0] w;
        logic [CW-1:0] sc;
        w = '0;
        for (int s = 0; s < NS; s++) begin
            sc = ref_seg(d[s*SW +: SW]);
`ifdef HAMMING_INTERLEAVE_EN
            for (int j = 0; j < CW; j++) w[j*NS + s] = sc[j];
`else
            w[s*CW +: CW] = sc;
`endif
        end
        return w;
    endfunction

    function automatic logic [CW-1:0] get_seg(input logic [OW-1:0] w, input int s);
        logic [CW-1:0] c;
`ifdef HAMMING_INTERLEAVE_EN
        for (int j = 0; j < CW; j++) c[j] = w[j*NS + s];
`else
        c = w[s*CW +: CW];
`endif
        return c;
    endfunction

    // Single-error-correcting decode: syndrome is the XOR of set positions.
    function automatic logic [SW-1:0] ref_decode(input logic [CW-1:0] cin);
        logic [CW-1:0] c;
        logic [SW-1:0] d;
        int syn;
        int k;
        c   = cin;
        syn = 0;
        for (int q = 1; q < CW; q++) if (c[q]) syn = syn ^ q;
        if (syn != 0 && syn < CW) c[syn] = ~c[syn];
        k = 0;
        d = '0;
        for (int q = 1; q < CW; q++) begin
            if ((q & (q - 1)) != 0) begin
                d[k] = c[q];
                k++;
            end
        end
        return d;
    endfunction

    // ---------------- compare process ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_seq = 0;
    bit            stalled = 1'b0;
    logic [OW-1:0] st_dat;
    logic [SQ-1:0] st_seq;
    bit            log_en = 1'b0;
    int            seq_log[$];

    always @(negedge clk) begin
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic [CW-1:0] ce;
        bit ok;
        if (rst) begin
            exp_q.delete();
            exp_seq = 0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(data_out), 64'(st_dat));
                check("stall_seq", 64'(out_seq), 64'(st_seq));
            end
            stalled = out_valid && !out_ready;
            st_dat  = data_out;
            st_seq  = out_seq;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got word %0h, expected none", data_out);
                end else begin
                    d = exp_q.pop_front();
                    check("model_data", 64'(data_out), 64'(ref_word(d)));
                    check("model_seq", 64'(out_seq), 64'(exp_seq % (1 << SQ)));
                    if (log_en) seq_log.push_back(int'(out_seq));
                    ok = 1'b1;
                    for (int s = 0; s < NS; s++) begin
                        c = get_seg(data_out, s);
                        if (^c) ok = 1'b0;
                        if (ref_decode(c) != d[s*SW +: SW]) ok = 1'b0;
                        for (int b = 0; b < CW; b++) begin
                            ce    = c;
                            ce[b] = ~ce[b];
                            if (ref_decode(ce) != d[s*SW +: SW]) ok = 1'b0;
                        end
                    end
                    check("ecc_single_bit_correct", 64'(ok), 64'd1);
                    exp_seq = (exp_seq + 1) % (1 << SQ);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(data_in);
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1; checks exact 2-clk latency and a literal codeword/tag.
    task automatic send_lit(input string tag, input logic [DW-1:0] d,
                            input logic [OW-1:0] lit, input logic [SQ-1:0] seq);
        in_valid = 1'b1;
        data_in  = d;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = ~d;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data_out"}, 64'(data_out), 64'(lit));
        check({tag, "_out_seq"}, 64'(out_seq), 64'(seq));
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] words [6] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678,
                                 32'h80000000, 32'hDEADBEEF, 32'h0F0F0F0F};
    bit            pat [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            exp_wrap [5] = '{0, 1, 2, 3, 0};

    initial begin
        int  i;
        bit  acc;

        // reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_seq", 64'(out_seq), 64'd0);
        @(posedge clk);
        #1;

        // literal codewords
        out_ready = 1'b1;
        send_lit("zero", 32'h00000000, 52'h0, 2'd0);
        send_lit("ones", 32'hFFFFFFFF, LIT_ONES, 2'd1);
        send_lit("one", 32'h00000001, LIT_ONE, 2'd2);

        // back-to-back with out_ready pattern 1,0,0,1
        i = 0;
        for (int c = 0; c < 300 && (i < 6 || exp_q.size() != 0); c++) begin
            out_ready = pat[c % 4];
            in_valid  = (i < 6);
            data_in   = (i < 6) ? words[i] : 32'h0;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        in_valid = 1'b0;
        check("b2b_all_sent", 64'(i), 64'd6);
        check("b2b_drained", 64'(exp_q.size()), 64'd0);

        // sequence wrap after a fresh reset
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        log_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            data_in  = 32'h01010101 * (k + 3);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 log_en = 1'b0;
        check("wrap_count", 64'(seq_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < seq_log.size()) check("wrap_seq", 64'(seq_log[k]), 64'(exp_wrap[k]));
        end

        // reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'hCAFEF00D;
        @(posedge clk);
        #1 data_in = 32'h13579BDF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_out_seq", 64'(out_seq), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("in_ready_follows_out_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_seq", 64'(out_seq), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);

        // a few more words through the model/ECC scoreboard
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            data_in  = words[(k + 2) % 6] ^ 32'hA5A55A5A;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
